// File: rtl/alu_multiciclo.sv
// Registered multi-cycle ALU: single-cycle logic/add/sub, iterative shift-add MUL and restoring DIV/MOD.
// Define ALU_MULDIV_SIGNED_EN to make MUL/DIV/MOD two's complement (magnitude iteration + sign fix).
`ifndef OP_NOP
  `define OP_NOP 5'h00
  `define OP_ADD 5'h01
  `define OP_SUB 5'h02
  `define OP_AND 5'h03
  `define OP_OR  5'h04
  `define OP_XOR 5'h05
  `define OP_NOT 5'h06
  `define OP_NEG 5'h07
  `define OP_MUL 5'h08
  `define OP_DIV 5'h09
  `define OP_MOD 5'h0A
  `define OP_HLT 5'h1F
`endif

module alu_multiciclo #(
  parameter int BITS_DATA   = 32,
  parameter int BITS_OPCODE = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   inicio,
  input  logic [BITS_OPCODE-1:0] opcode,
  input  logic [BITS_DATA-1:0]   operando_a,
  input  logic [BITS_DATA-1:0]   operando_b,
  output logic                   ocupado,
  output logic                   valido,
  output logic [BITS_DATA-1:0]   resultado,
  output logic                   C,
  output logic                   S,
  output logic                   O,
  output logic                   Z,
  output logic                   error,
  output logic [1:0]             estado_dbg
);
  localparam int W  = BITS_DATA;
  localparam int CW = $clog2(BITS_DATA) + 1;

  // Handshake: inicio is taken only on an edge where ocupado=0; valido is a
  // one-cycle pulse during FIN, and the result/flag outputs change only then.
  typedef enum logic [1:0] {IDLE = 2'd0, ITERA = 2'd1, FIN = 2'd2} estado_t;
  estado_t estado;

  logic [CW-1:0] cnt;
  logic          es_mul, es_mod;
  logic [W-1:0]  opnd, acc_hi, acc_lo;
`ifdef ALU_MULDIV_SIGNED_EN
  logic          neg_q, neg_r;
`endif

  // Single-cycle datapath on the live inputs
  logic [W:0]   sum, diff;
  logic [W-1:0] s_res;
  logic         s_c, s_o, s_err, s_keep, s_iter, s_flags_zero;

  always_comb begin
    sum          = {1'b0, operando_a} + {1'b0, operando_b};
    diff         = {1'b0, operando_a} - {1'b0, operando_b};
    s_res        = '0;
    s_c          = 1'b0;
    s_o          = 1'b0;
    s_err        = 1'b0;
    s_keep       = 1'b0;
    s_iter       = 1'b0;
    s_flags_zero = 1'b0;
    case (opcode)
      `OP_ADD: begin
        s_res = sum[W-1:0];
        s_c   = sum[W];
        s_o   = (operando_a[W-1] == operando_b[W-1]) && (sum[W-1] != operando_a[W-1]);
      end
      `OP_SUB: begin
        s_res = diff[W-1:0];
        s_c   = diff[W];
        s_o   = (operando_a[W-1] != operando_b[W-1]) && (diff[W-1] != operando_a[W-1]);
      end
      `OP_AND: s_res = operando_a & operando_b;
      `OP_OR:  s_res = operando_a | operando_b;
      `OP_XOR: s_res = operando_a ^ operando_b;
      `OP_NOT: s_res = ~operando_a;
      `OP_NEG: s_res = -operando_a;
      `OP_NOP, `OP_HLT: s_keep = 1'b1;
      `OP_MUL: s_iter = 1'b1;
      `OP_DIV: begin
        if (operando_b == '0) begin
          s_res = '1;
          s_err = 1'b1;
        end else s_iter = 1'b1;
      end
      `OP_MOD: begin
        if (operando_b == '0) begin
          s_res = operando_a;
          s_err = 1'b1;
        end else s_iter = 1'b1;
      end
      default: begin
        s_err        = 1'b1;
        s_flags_zero = 1'b1;
      end
    endcase
  end

  // Operand magnitudes fed to the iterative engine
  logic [W-1:0] a_mag, b_mag;
`ifdef ALU_MULDIV_SIGNED_EN
  assign a_mag = operando_a[W-1] ? -operando_a : operando_a;
  assign b_mag = operando_b[W-1] ? -operando_b : operando_b;
`else
  assign a_mag = operando_a;
  assign b_mag = operando_b;
`endif

  // One iteration step: MUL keeps {acc_hi,acc_lo} as the shifting product,
  // DIV/MOD keep the partial remainder in acc_hi and the quotient in acc_lo.
  logic [W:0]   mul_sum, rem_sh, trial;
  logic [W-1:0] nx_hi, nx_lo;

  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc_hi, acc_lo[W-1]};
    trial   = rem_sh - {1'b0, opnd};
    if (es_mul) begin
      nx_hi = mul_sum[W:1];
      nx_lo = {mul_sum[0], acc_lo[W-1:1]};
    end else if (!trial[W]) begin
      nx_hi = trial[W-1:0];
      nx_lo = {acc_lo[W-2:0], 1'b1};
    end else begin
      nx_hi = rem_sh[W-1:0];
      nx_lo = {acc_lo[W-2:0], 1'b0};
    end
  end

  // Final result of an iterative op, taken from the last step's values
  logic [W-1:0] f_res;
  logic         f_ov;
`ifdef ALU_MULDIV_SIGNED_EN
  logic [2*W-1:0] prod, sprod;
  always_comb begin
    prod  = {nx_hi, nx_lo};
    sprod = neg_q ? -prod : prod;
    f_res = '0;
    f_ov  = 1'b0;
    if (es_mul) begin
      f_res = sprod[W-1:0];
      f_ov  = sprod[2*W-1:W] != {W{sprod[W-1]}};
    end else if (es_mod) begin
      f_res = neg_r ? -nx_hi : nx_hi;
    end else begin
      // A positive quotient with the MSB set only arises from most-negative / -1
      f_res = neg_q ? -nx_lo : nx_lo;
      f_ov  = !neg_q && nx_lo[W-1];
    end
  end
`else
  always_comb begin
    f_res = es_mul ? nx_lo : (es_mod ? nx_hi : nx_lo);
    f_ov  = es_mul && (nx_hi != '0);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= IDLE;
      cnt       <= '0;
      es_mul    <= 1'b0;
      es_mod    <= 1'b0;
      opnd      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      valido    <= 1'b0;
      resultado <= '0;
      C         <= 1'b0;
      S         <= 1'b0;
      O         <= 1'b0;
      Z         <= 1'b0;
      error     <= 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (estado)
        IDLE: begin
          valido <= 1'b0;
          if (inicio) begin
            if (s_iter) begin
              es_mul <= (opcode == `OP_MUL);
              es_mod <= (opcode == `OP_MOD);
              opnd   <= (opcode == `OP_MUL) ? a_mag : b_mag;
              acc_lo <= (opcode == `OP_MUL) ? b_mag : a_mag;
              acc_hi <= '0;
              cnt    <= CW'(BITS_DATA);
`ifdef ALU_MULDIV_SIGNED_EN
              neg_q  <= operando_a[W-1] ^ operando_b[W-1];
              neg_r  <= operando_a[W-1];
`endif
              estado <= ITERA;
            end else begin
              valido <= 1'b1;
              error  <= s_err;
              if (!s_keep) begin
                resultado <= s_res;
                C         <= s_c;
                O         <= s_o;
                S         <= !s_flags_zero && s_res[W-1];
                Z         <= !s_flags_zero && (s_res == '0);
              end
              estado <= FIN;
            end
          end
        end
        ITERA: begin
          acc_hi <= nx_hi;
          acc_lo <= nx_lo;
          if (cnt == CW'(1)) begin
            valido    <= 1'b1;
            error     <= 1'b0;
            resultado <= f_res;
            C         <= f_ov;
            O         <= f_ov;
            S         <= f_res[W-1];
            Z         <= (f_res == '0);
            estado    <= FIN;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FIN: begin
          valido <= 1'b0;
          estado <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

  assign ocupado    = (estado != IDLE);
  assign estado_dbg = estado;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: arithmetic reference model, per-cycle compare, directed and random ops.
module tb_alu_multiciclo;
  localparam int W = 32;
  localparam logic [4:0] K_NOP = 5'h00, K_ADD = 5'h01, K_SUB = 5'h02, K_AND = 5'h03,
                         K_OR  = 5'h04, K_XOR = 5'h05, K_NOT = 5'h06, K_NEG = 5'h07,
                         K_MUL = 5'h08, K_DIV = 5'h09, K_MOD = 5'h0A, K_HLT = 5'h1F;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         inicio = 1'b0;
  logic [4:0]   opcode = '0;
  logic [W-1:0] operando_a = '0, operando_b = '0;
  logic         ocupado, valido, C, S, O, Z, error;
  logic [W-1:0] resultado;
  logic [1:0]   estado_dbg;

  alu_multiciclo #(.BITS_DATA(W), .BITS_OPCODE(5)) dut (
    .clk(clk), .reset_n(reset_n), .inicio(inicio), .opcode(opcode),
    .operando_a(operando_a), .operando_b(operando_b), .ocupado(ocupado),
    .valido(valido), .resultado(resultado), .C(C), .S(S), .O(O), .Z(Z),
    .error(error), .estado_dbg(estado_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  bit  checks_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: packed expectation {error,C,S,O,Z,resultado}
  logic [W+4:0] exp_q[$];
  logic [W+4:0] cur = '0;
  int           m_left = 0;

  function automatic bit fits32(input longint v);
    return (v <= 64'sd2147483647) && (v >= -64'sd2147483648);
  endfunction

  function automatic void model_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W+4:0] r, output int lat);
    longint sa, sb, t;
    logic [63:0] p;
    logic [W-1:0] res;
    logic c, o, e, fz;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0; c = 0; o = 0; e = 0; fz = 0; lat = 1;
    case (op)
      K_ADD: begin
        p = {32'b0, a} + {32'b0, b};
        res = p[31:0]; c = p[32]; o = !fits32(sa + sb);
      end
      K_SUB: begin
        res = a - b; c = (a < b); o = !fits32(sa - sb);
      end
      K_AND: res = a & b;
      K_OR:  res = a | b;
      K_XOR: res = a ^ b;
      K_NOT: res = ~a;
      K_NEG: res = -a;
      K_NOP, K_HLT: begin
        r = {1'b0, cur[W+3:0]};
        return;
      end
      K_MUL: begin
        lat = W + 1;
`ifdef ALU_MULDIV_SIGNED_EN
        t = sa * sb; p = t; res = p[31:0]; o = !fits32(t); c = o;
`else
        p = {32'b0, a} * {32'b0, b}; res = p[31:0]; o = (p[63:32] != 0); c = o;
`endif
      end
      K_DIV, K_MOD: begin
        if (b == 0) begin
          e = 1; res = (op == K_DIV) ? '1 : a;
        end else begin
          lat = W + 1;
`ifdef ALU_MULDIV_SIGNED_EN
          if (op == K_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = a; o = 1;
          end else begin
            t = (op == K_DIV) ? sa / sb : sa % sb;
            p = t; res = p[31:0];
          end
`else
          res = (op == K_DIV) ? a / b : a % b;
`endif
        end
      end
      default: begin
        e = 1; fz = 1;
      end
    endcase
    r = {e, c, (!fz && res[W-1]), o, (!fz && res == 0), res};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic [W+4:0] r;
    int lat;
    if (!reset_n) begin
      m_left = 0;
      exp_q.delete();
      cur = '0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 1 && exp_q.size() > 0) cur = exp_q.pop_front();
    end else if (inicio) begin
      model_op(opcode, operando_a, operando_b, r, lat);
      exp_q.push_back(r);
      m_left = lat;
      if (lat == 1) cur = exp_q.pop_front();
    end
  end

  // Per-cycle compare: {ocupado,valido,error,C,S,O,Z,resultado}
  always @(negedge clk) begin
    if (checks_on && reset_n)
      check("cycle_outputs", {ocupado, valido, error, C, S, O, Z, resultado},
            {(m_left != 0), (m_left == 1), cur});
  end

  // Driver tasks
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    @(negedge clk);
    opcode = op; operando_a = a; operando_b = b; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    lat = 1;
    while (!valido && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!valido) begin
      checks++; failures++;
      $display("FAIL valido_timeout op=%h waited=%0d", op, lat);
    end
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] op_list [0:15];
  int lat, pulses;

  initial begin
    op_list = '{K_NOP, K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOT, K_NEG,
                K_MUL, K_DIV, K_MOD, K_HLT, K_ADD, K_SUB, 5'h0C, 5'h15};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checks_on = 1'b1;
    check("reset_state", {ocupado, valido, error, C, S, O, Z, resultado, estado_dbg}, '0);

    run_op(K_ADD, 32'h7FFF_FFFF, 32'h1, lat);
    check("add_ovf_lat", lat, 1);
    check("add_ovf_res", resultado, 32'h8000_0000);
    check("add_ovf_flags", {C, S, O, Z}, 4'b0110);
    run_op(K_ADD, 32'hFFFF_FFFF, 32'h1, lat);
    check("add_carry_res", resultado, 0);
    check("add_carry_flags", {C, Z, error}, 3'b110);

    run_op(K_MUL, 32'h0001_0000, 32'h0001_0000, lat);
    check("mul_big_lat", lat, 33);
    check("mul_big_res", resultado, 0);
    check("mul_big_flags", {C, O, Z}, 3'b111);
    run_op(K_MUL, 7, 6, lat);
    check("mul_small_res", resultado, 42);
    check("mul_small_c", {C, O}, 2'b00);

    run_op(K_DIV, 100, 7, lat);
    check("div_lat", lat, 33);
    check("div_res", {error, resultado}, {1'b0, 32'd14});
    run_op(K_MOD, 100, 7, lat);
    check("mod_lat", lat, 33);
    check("mod_res", {error, resultado}, {1'b0, 32'd2});
    run_op(K_DIV, 5, 0, lat);
    check("div0_lat", lat, 1);
    check("div0_res", {error, resultado}, {1'b1, 32'hFFFF_FFFF});

    run_op(K_NOP, 1, 2, lat);
    check("nop_hold", {error, resultado}, {1'b0, 32'hFFFF_FFFF});
    run_op(5'h0C, 9, 9, lat);
    check("invalid_op", {error, C, S, O, Z, resultado}, {5'b10000, 32'd0});

    // inicio held high through a MUL: only one acceptance
    @(negedge clk);
    opcode = K_MUL; operando_a = 3; operando_b = 5; inicio = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valido) begin
        pulses++;
        inicio = 1'b0;
      end
    end
    inicio = 1'b0;
    check("spam_pulses", pulses, 1);
    check("spam_res", resultado, 15);

    // Reset during ITERA cycle 10 of a DIV
    @(negedge clk);
    opcode = K_DIV; operando_a = 1000; operando_b = 3; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("midop_reset", {ocupado, valido, error, C, S, O, Z, resultado, estado_dbg}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valido) pulses++;
    end
    check("no_valido_after_reset", pulses, 0);
    run_op(K_ADD, 2, 3, lat);
    check("post_reset_add", {lat[7:0], resultado}, {8'd1, 32'd5});

`ifdef ALU_MULDIV_SIGNED_EN
    run_op(K_DIV, -32'sd7, 2, lat);
    check("sdiv_res", resultado, 32'hFFFF_FFFD);
    run_op(K_MOD, -32'sd7, 2, lat);
    check("smod_res", resultado, 32'hFFFF_FFFF);
    run_op(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("sdiv_min", {error, O, resultado}, {2'b01, 32'h8000_0000});
`endif

    // Randomized traffic, including inicio while busy
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      inicio     = ($urandom_range(0, 3) != 0);
      opcode     = op_list[$urandom_range(0, 15)];
      operando_a = pick_val();
      operando_b = pick_val();
    end
    @(negedge clk);
    inicio = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
